// File: rtl/usb_nrzi_line_receiver.sv
// USB NRZI line receiver: bit-phase recovery, SYNC detection, NRZI decode, bit unstuffing and EOP handling.
// Build option USB_RX_STUFF_ERR_CHECK_EN: a 1 in the stuffed-bit slot aborts the packet with rx_error.
module usb_nrzi_line_receiver #(
  parameter int unsigned BIT_PERIOD = 4,
  parameter int unsigned SYNC_BITS  = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] J_state,
  input  logic [1:0] K_state,
  input  logic [1:0] usb_signals,
  input  logic       rx_enable,
  output logic       serial_data_out,
  output logic       serial_data_out_val,
  output logic       serial_data_out_last,
  output logic       sync_detected,
  output logic       rx_active,
  output logic       rx_error
);

  localparam int unsigned PH_W   = $clog2(BIT_PERIOD);
  localparam int unsigned ZC_W   = $clog2(SYNC_BITS);
  localparam int unsigned ONES_W = 3;

  localparam logic [PH_W-1:0]   PH_MAX     = PH_W'(BIT_PERIOD - 1);
  localparam logic [PH_W-1:0]   PH_SAMPLE  = PH_W'(BIT_PERIOD / 2 - 1);
  localparam logic [ZC_W-1:0]   ZC_NEED    = ZC_W'(SYNC_BITS - 1);
  localparam logic [ONES_W-1:0] ONES_STUFF = ONES_W'(6);

  typedef enum logic [1:0] {S_IDLE, S_SYNC, S_DATA, S_EOP} state_t;

  state_t            state;
  logic [1:0]        line_q;
  logic [1:0]        prev_samp;
  logic [PH_W-1:0]   phase;
  logic [ZC_W-1:0]   zero_cnt;
  logic [ONES_W-1:0] ones_cnt;
  logic              held_bit;
  logic              held_val;

  logic line_changed_c;
  logic bit_sample_c;
  logic dec_bit_c;
  logic is_se0_c;

  // Mid-bit strobe, realigned by every line transition
  assign line_changed_c = (usb_signals != line_q);
  assign bit_sample_c   = (phase == PH_SAMPLE) && !line_changed_c;
  assign dec_bit_c      = (usb_signals == prev_samp);
  assign is_se0_c       = (usb_signals == 2'b00);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state                <= S_IDLE;
      line_q               <= J_state;
      prev_samp            <= J_state;
      phase                <= '0;
      zero_cnt             <= '0;
      ones_cnt             <= '0;
      held_bit             <= 1'b0;
      held_val             <= 1'b0;
      serial_data_out      <= 1'b0;
      serial_data_out_val  <= 1'b0;
      serial_data_out_last <= 1'b0;
      sync_detected        <= 1'b0;
      rx_active            <= 1'b0;
      rx_error             <= 1'b0;
    end else begin
      serial_data_out_val  <= 1'b0;
      serial_data_out_last <= 1'b0;
      sync_detected        <= 1'b0;
      rx_error             <= 1'b0;
      line_q               <= usb_signals;
      phase                <= (line_changed_c || phase == PH_MAX) ? '0 : phase + PH_W'(1);
      if (bit_sample_c) prev_samp <= usb_signals;

      if (state != S_IDLE && !rx_enable) begin
        // Host took the bus: drop whatever is in flight
        state     <= S_IDLE;
        rx_active <= 1'b0;
        rx_error  <= 1'b1;
        held_val  <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            // Idle line is J, so the first SYNC K decodes as a 0 against J
            if (rx_enable && line_changed_c && usb_signals == K_state) begin
              state     <= S_SYNC;
              phase     <= '0;
              prev_samp <= J_state;
              zero_cnt  <= '0;
              rx_active <= 1'b1;
            end
          end
          S_SYNC: begin
            if (bit_sample_c) begin
              if (!dec_bit_c) begin
                if (zero_cnt != ZC_NEED) zero_cnt <= zero_cnt + ZC_W'(1);
              end else if (zero_cnt == ZC_NEED) begin
                state         <= S_DATA;
                sync_detected <= 1'b1;
                ones_cnt      <= '0;
                held_val      <= 1'b0;
              end else begin
                state     <= S_IDLE;
                rx_active <= 1'b0;
              end
            end
          end
          S_DATA: begin
            if (bit_sample_c) begin
              if (is_se0_c) begin
                if (held_val) begin
                  serial_data_out      <= held_bit;
                  serial_data_out_val  <= 1'b1;
                  serial_data_out_last <= 1'b1;
                end
                held_val <= 1'b0;
                state    <= S_EOP;
              end else if (ones_cnt == ONES_STUFF) begin
                ones_cnt <= '0;
`ifdef USB_RX_STUFF_ERR_CHECK_EN
                if (dec_bit_c) begin
                  rx_error <= 1'b1;
                  held_val <= 1'b0;
                  state    <= S_EOP;
                end
`endif
              end else begin
                // One-bit holdback so the final bit can carry last
                if (held_val) begin
                  serial_data_out     <= held_bit;
                  serial_data_out_val <= 1'b1;
                end
                held_bit <= dec_bit_c;
                held_val <= 1'b1;
                ones_cnt <= dec_bit_c ? ones_cnt + ONES_W'(1) : '0;
              end
            end
          end
          S_EOP: begin
            if (bit_sample_c) begin
              if (usb_signals == J_state) begin
                state     <= S_IDLE;
                rx_active <= 1'b0;
              end else if (usb_signals == K_state) begin
                state     <= S_IDLE;
                rx_active <= 1'b0;
                rx_error  <= 1'b1;
              end
            end
          end
          default: begin
            state     <= S_IDLE;
            rx_active <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_usb_nrzi_line_receiver.sv
// Self-checking bench for usb_nrzi_line_receiver: line waveforms are built from data bytes
// (stuffing + NRZI encoding), decoded output is compared against the original data.
module tb_usb_nrzi_line_receiver;

  localparam int BP = 4;
  localparam logic [1:0] JS  = 2'b10;
  localparam logic [1:0] KS  = 2'b01;
  localparam logic [1:0] SE0 = 2'b00;
  localparam int IDLE_BITS = 3;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] J_state = JS;
  logic [1:0] K_state = KS;
  logic [1:0] usb_signals = JS;
  logic       rx_enable = 1'b1;
  logic       serial_data_out;
  logic       serial_data_out_val;
  logic       serial_data_out_last;
  logic       sync_detected;
  logic       rx_active;
  logic       rx_error;

  usb_nrzi_line_receiver #(.BIT_PERIOD(BP), .SYNC_BITS(8)) dut (
    .clock                (clock),
    .reset                (reset),
    .J_state              (J_state),
    .K_state              (K_state),
    .usb_signals          (usb_signals),
    .rx_enable            (rx_enable),
    .serial_data_out      (serial_data_out),
    .serial_data_out_val  (serial_data_out_val),
    .serial_data_out_last (serial_data_out_last),
    .sync_detected        (sync_detected),
    .rx_active            (rx_active),
    .rx_error             (rx_error)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  logic       dat_q[$];
  logic       raw_q[$];
  logic       exp_q[$];
  logic       got_q[$];
  logic [1:0] sym_q[$];
  logic [1:0] wave[$];

  int   last_cnt = 0;
  int   last_idx = -1;
  int   sync_cnt = 0;
  int   err_cnt = 0;
  int   hold_bad = 0;
  logic act_seen = 1'b0;
  logic prev_out = 1'b0;

  // Output monitor, sampled on the falling edge
  always @(negedge clock) begin
    if (!reset) begin
      if (serial_data_out_val) begin
        got_q.push_back(serial_data_out);
        if (serial_data_out_last) last_idx = got_q.size();
      end
      if (serial_data_out_last) last_cnt++;
      if (!serial_data_out_val && serial_data_out !== prev_out) hold_bad++;
      if (sync_detected) sync_cnt++;
      if (rx_error) err_cnt++;
      if (rx_active) act_seen = 1'b1;
    end
    prev_out = serial_data_out;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] pack(input logic q[$]);
    logic [63:0] v;
    v = '0;
    foreach (q[i]) if (i < 64) v[i] = q[i];
    return v;
  endfunction

  task automatic clear_mon();
    got_q.delete();
    last_cnt = 0;
    last_idx = -1;
    sync_cnt = 0;
    err_cnt  = 0;
    hold_bad = 0;
    act_seen = 1'b0;
  endtask

  task automatic add_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) dat_q.push_back(b[i]);
  endtask

  // Insert a 0 after every run of six 1s
  task automatic stuff_data();
    int ones;
    ones = 0;
    raw_q.delete();
    foreach (dat_q[i]) begin
      raw_q.push_back(dat_q[i]);
      ones = dat_q[i] ? ones + 1 : 0;
      if (ones == 6) begin
        raw_q.push_back(1'b0);
        ones = 0;
      end
    end
  endtask

  // Idle J, SYNC KJKJKJKK, NRZI-encoded raw bits, SE0 SE0 J, idle J
  task automatic build_packet();
    logic [1:0] st;
    sym_q.delete();
    for (int i = 0; i < IDLE_BITS; i++) sym_q.push_back(JS);
    for (int i = 0; i < 7; i++) sym_q.push_back((i % 2 == 0) ? KS : JS);
    sym_q.push_back(KS);
    st = KS;
    foreach (raw_q[i]) begin
      if (!raw_q[i]) st = (st == JS) ? KS : JS;
      sym_q.push_back(st);
    end
    sym_q.push_back(SE0);
    sym_q.push_back(SE0);
    for (int i = 0; i < 4; i++) sym_q.push_back(JS);
  endtask

  // mode 0: nominal; 1: random edges one cycle early; 2: every edge one cycle early
  task automatic make_wave(input int mode);
    wave.delete();
    foreach (sym_q[i]) for (int c = 0; c < BP; c++) wave.push_back(sym_q[i]);
    if (mode != 0) begin
      for (int i = 1; i < sym_q.size(); i++) begin
        if (sym_q[i] != sym_q[i-1] && (mode == 2 || $urandom_range(1, 0) == 1))
          wave[i*BP-1] = sym_q[i];
      end
    end
  endtask

  task automatic play(input int from, input int to);
    for (int i = from; i < to; i++) begin
      usb_signals = wave[i];
      @(posedge clock); #1;
    end
  endtask

  task automatic idle_cycles(input int n);
    usb_signals = JS;
    repeat (n) begin @(posedge clock); #1; end
  endtask

  task automatic check_pkt(input string tag, input int exp_sync, input int exp_last, input int exp_err);
    check($sformatf("%s:nval", tag), 64'(got_q.size()), 64'(exp_q.size()));
    check($sformatf("%s:bits", tag), pack(got_q), pack(exp_q));
    check($sformatf("%s:last", tag), 64'(last_cnt), 64'(exp_last));
    if (exp_last != 0) check($sformatf("%s:last_pos", tag), 64'(last_idx), 64'(exp_q.size()));
    check($sformatf("%s:sync", tag), 64'(sync_cnt), 64'(exp_sync));
    check($sformatf("%s:err", tag), 64'(err_cnt), 64'(exp_err));
    check($sformatf("%s:hold", tag), 64'(hold_bad), 64'(0));
    check($sformatf("%s:active_seen", tag), 64'(act_seen), 64'(1));
    check($sformatf("%s:active_end", tag), 64'(rx_active), 64'(0));
  endtask

  task automatic run_normal(input string tag, input int mode);
    stuff_data();
    exp_q = dat_q;
    build_packet();
    make_wave(mode);
    clear_mon();
    play(0, wave.size());
    check_pkt(tag, 1, 1, 0);
  endtask

  initial begin
    repeat (3) @(posedge clock);
    #1;
    check("reset_outs", 64'({serial_data_out, serial_data_out_val, serial_data_out_last,
                             sync_detected, rx_active, rx_error}), 64'(0));
    reset = 1'b0;
    idle_cycles(4);

    // Basic packet 8'hA5
    dat_q.delete(); add_byte(8'hA5);
    run_normal("a5", 0);

    // All ones: stuffed 0 after the sixth 1 must vanish
    dat_q.delete(); add_byte(8'hFF);
    run_normal("ff_stuff", 0);

    // Seven unstuffed 1s on the line, then EOP
    raw_q.delete();
    for (int i = 0; i < 7; i++) raw_q.push_back(1'b1);
    build_packet(); make_wave(0); clear_mon();
    play(0, wave.size());
    exp_q.delete();
`ifdef USB_RX_STUFF_ERR_CHECK_EN
    for (int i = 0; i < 5; i++) exp_q.push_back(1'b1);
    check_pkt("seven_ones", 1, 0, 1);
`else
    for (int i = 0; i < 6; i++) exp_q.push_back(1'b1);
    check_pkt("seven_ones", 1, 1, 0);
`endif

    // Broken SYNC: KJKJJ
    sym_q.delete();
    for (int i = 0; i < IDLE_BITS; i++) sym_q.push_back(JS);
    sym_q.push_back(KS); sym_q.push_back(JS); sym_q.push_back(KS);
    sym_q.push_back(JS); sym_q.push_back(JS);
    for (int i = 0; i < 4; i++) sym_q.push_back(JS);
    make_wave(0); clear_mon(); exp_q.delete();
    play(0, wave.size());
    check_pkt("early_sync", 0, 0, 0);

    // rx_enable drops after three data bits
    dat_q.delete(); add_byte(8'hA5);
    stuff_data(); build_packet(); make_wave(0); clear_mon();
    play(0, (IDLE_BITS + 8 + 3) * BP);
    rx_enable = 1'b0;
    idle_cycles(8);
    exp_q.delete(); exp_q.push_back(1'b1); exp_q.push_back(1'b0);
    check_pkt("abort", 1, 0, 1);
    rx_enable = 1'b1;
    idle_cycles(4);

    // Asynchronous reset in the middle of DATA
    dat_q.delete(); add_byte(8'hA5);
    stuff_data(); build_packet(); make_wave(0); clear_mon();
    play(0, (IDLE_BITS + 8 + 4) * BP);
    check("pre_reset_active", 64'(rx_active), 64'(1));
    #2 reset = 1'b1;
    #1;
    check("mid_reset_outs", 64'({serial_data_out, serial_data_out_val, serial_data_out_last,
                                 sync_detected, rx_active, rx_error}), 64'(0));
    clear_mon();
    usb_signals = JS;
    @(posedge clock); #1;
    reset = 1'b0;
    idle_cycles(40);
    check("post_reset_nval", 64'(got_q.size()), 64'(0));
    check("post_reset_last_err", 64'(last_cnt + err_cnt + sync_cnt), 64'(0));
    check("post_reset_active", 64'(rx_active), 64'(0));
    dat_q.delete(); add_byte(8'h3C);
    run_normal("post_reset_pkt", 0);

    // Every edge arrives one cycle early
    dat_q.delete(); add_byte(8'hA5);
    run_normal("jitter_a5", 2);

    // Randomized packets with random early edges
    for (int p = 0; p < 8; p++) begin
      int nb;
      nb = $urandom_range(3, 1);
      dat_q.delete();
      for (int b = 0; b < nb; b++)
        add_byte(($urandom_range(3, 0) == 0) ? 8'hFF : 8'($urandom));
      run_normal($sformatf("rand%0d", p), int'($urandom_range(1, 0)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
